// File: rtl/mybul_app_pkg.sv
// Shared game definitions: direction encodings, park coordinate and the
// bullet state encoding used by the bullet and tank blocks.
package mybul_app_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_COOL = 2'b10
  } game_state_e;

  localparam logic [4:0] PARK_POS = 5'd31;

endpackage

// File: rtl/mybul_app_grid_step.sv
// One-cell move of a grid position in a given direction, with an
// out-of-field flag computed before any 5-bit wrap can be seen.
module grid_step
  import mybul_app_pkg::*;
#(
  parameter int X_MAX = 15,
  parameter int Y_MAX = 19
) (
  input  logic [4:0] pos_x,
  input  logic [4:0] pos_y,
  input  logic [1:0] dir,
  output logic [4:0] nxt_x,
  output logic [4:0] nxt_y,
  output logic       oof
);

  localparam logic [5:0] X_LIM = 6'(X_MAX);
  localparam logic [5:0] Y_LIM = 6'(Y_MAX);

  logic [5:0] inc_x_s;
  logic [5:0] inc_y_s;

  assign inc_x_s = {1'b0, pos_x} + 6'd1;
  assign inc_y_s = {1'b0, pos_y} + 6'd1;

  // Next cell and bounds: increments checked on the 6-bit sum, decrements on borrow.
  always_comb begin
    nxt_x = pos_x;
    nxt_y = pos_y;
    oof   = 1'b0;
    case (dir)
      DIR_UP: begin
        nxt_y = inc_y_s[4:0];
        oof   = (inc_y_s > Y_LIM);
      end
      DIR_DOWN: begin
        nxt_y = pos_y - 5'd1;
        oof   = (pos_y == 5'd0);
      end
      DIR_LEFT: begin
        nxt_x = inc_x_s[4:0];
        oof   = (inc_x_s > X_LIM);
      end
      DIR_RIGHT: begin
        nxt_x = pos_x - 5'd1;
        oof   = (pos_x == 5'd0);
      end
      default: begin
        oof = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mybul_app.sv
// Single tank bullet: launches on a shot edge, advances on step ticks,
// ends on field exit or hit, then waits out a cooldown before rearming.
module mybul_app
  import mybul_app_pkg::*;
#(
  parameter int FIELD_X_MAX    = 15,
  parameter int FIELD_Y_MAX    = 19,
  parameter int COOLDOWN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_tick,
  input  logic       bul_en,
  input  logic       bul_sht,
  input  logic [1:0] tank_dir,
  input  logic [4:0] tank_x,
  input  logic [4:0] tank_y,
  input  logic       hit_in,
  output logic [4:0] bul_x,
  output logic [4:0] bul_y,
  output logic       bul_active,
  output logic [1:0] bul_dir,
  output logic       bul_fired
);

  localparam int CNT_W = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  game_state_e state_r, state_nxt_s;
  logic [4:0]       bul_x_r, bul_x_nxt_s;
  logic [4:0]       bul_y_r, bul_y_nxt_s;
  logic [1:0]       bul_dir_r, bul_dir_nxt_s;
  logic             bul_active_r, bul_active_nxt_s;
  logic             bul_fired_r, bul_fired_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             sht_q_r;

  logic             shot_req_s;
  logic [4:0]       step_in_x_s, step_in_y_s;
  logic [1:0]       step_in_dir_s;
  logic [4:0]       step_x_s, step_y_s;
  logic             step_oof_s;

  assign shot_req_s = bul_sht & ~sht_q_r;

  // One stepper serves both spawn (from the tank) and flight (from the bullet).
  always_comb begin
    step_in_x_s   = tank_x;
    step_in_y_s   = tank_y;
    step_in_dir_s = tank_dir;
    if (state_r == ST_FLY) begin
      step_in_x_s   = bul_x_r;
      step_in_y_s   = bul_y_r;
      step_in_dir_s = bul_dir_r;
    end else begin
      step_in_x_s   = tank_x;
      step_in_y_s   = tank_y;
      step_in_dir_s = tank_dir;
    end
  end

  grid_step #(
    .X_MAX (FIELD_X_MAX),
    .Y_MAX (FIELD_Y_MAX)
  ) u_grid_step (
    .pos_x (step_in_x_s),
    .pos_y (step_in_y_s),
    .dir   (step_in_dir_s),
    .nxt_x (step_x_s),
    .nxt_y (step_y_s),
    .oof   (step_oof_s)
  );

  // Next-state and next-output logic; every path ending a flight parks the bullet.
  always_comb begin
    state_nxt_s      = state_r;
    bul_x_nxt_s      = bul_x_r;
    bul_y_nxt_s      = bul_y_r;
    bul_dir_nxt_s    = bul_dir_r;
    bul_active_nxt_s = bul_active_r;
    bul_fired_nxt_s  = 1'b0;
    cnt_nxt_s        = cnt_r;
    if (!bul_en) begin
      state_nxt_s      = ST_IDLE;
      bul_x_nxt_s      = PARK_POS;
      bul_y_nxt_s      = PARK_POS;
      bul_active_nxt_s = 1'b0;
      cnt_nxt_s        = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (shot_req_s && !step_oof_s) begin
            state_nxt_s      = ST_FLY;
            bul_x_nxt_s      = step_x_s;
            bul_y_nxt_s      = step_y_s;
            bul_dir_nxt_s    = tank_dir;
            bul_active_nxt_s = 1'b1;
            bul_fired_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FLY: begin
          // A hit outranks a coincident tick: the bullet never moves past a target.
          if (hit_in || (step_tick && step_oof_s)) begin
            state_nxt_s      = ST_COOL;
            bul_x_nxt_s      = PARK_POS;
            bul_y_nxt_s      = PARK_POS;
            bul_active_nxt_s = 1'b0;
            cnt_nxt_s        = CNT_LOAD;
          end else if (step_tick) begin
            bul_x_nxt_s = step_x_s;
            bul_y_nxt_s = step_y_s;
          end else begin
            state_nxt_s = ST_FLY;
          end
        end
        ST_COOL: begin
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = ST_IDLE;
          end else if (step_tick) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else begin
            state_nxt_s = ST_COOL;
          end
        end
        default: begin
          state_nxt_s      = ST_IDLE;
          bul_x_nxt_s      = PARK_POS;
          bul_y_nxt_s      = PARK_POS;
          bul_active_nxt_s = 1'b0;
          cnt_nxt_s        = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bul_x_r      <= PARK_POS;
      bul_y_r      <= PARK_POS;
      bul_dir_r    <= 2'b00;
      bul_active_r <= 1'b0;
      bul_fired_r  <= 1'b0;
      cnt_r        <= CNT_ZERO;
      sht_q_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bul_x_r      <= bul_x_nxt_s;
      bul_y_r      <= bul_y_nxt_s;
      bul_dir_r    <= bul_dir_nxt_s;
      bul_active_r <= bul_active_nxt_s;
      bul_fired_r  <= bul_fired_nxt_s;
      cnt_r        <= cnt_nxt_s;
      sht_q_r      <= bul_sht;
    end
  end

  assign bul_x      = bul_x_r;
  assign bul_y      = bul_y_r;
  assign bul_active = bul_active_r;
  assign bul_dir    = bul_dir_r;
  assign bul_fired  = bul_fired_r;

endmodule

// File: doc/mybul_app.md
MYBUL_APP -- requirements
Module: mybul_app

Interface
REQ-001 Parameter FIELD_X_MAX, default 15: highest legal x cell.
REQ-002 Parameter FIELD_Y_MAX, default 19: highest legal y cell.
REQ-003 Parameter COOLDOWN_TICKS, default 2: number of step ticks after a bullet ends before a new shot is accepted.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 step_tick  in  1: one-clk-wide movement strobe (the 4 Hz rate, synchronised to clk).
REQ-007 bul_en  in  1: enables the bullet (tank alive and game running).
REQ-008 bul_sht  in  1: shoot level from the tank module; a 0->1 transition requests a shot.
REQ-009 tank_dir  in  2: tank direction; 00 up (y+1), 01 down (y-1), 10 left (x+1), 11 right (x-1).
REQ-010 tank_x, tank_y  in  5 each: tank cell position.
REQ-011 hit_in  in  1: target logic reports that the bullet occupies a tank cell.
REQ-012 bul_x, bul_y  out  5 each: bullet cell; 5'd31 on both when inactive.
REQ-013 bul_active  out  1: bullet in flight.
REQ-014 bul_dir  out  2: direction latched at launch.
REQ-015 bul_fired  out  1: one-clk pulse when a shot is launched.

Function
REQ-016 States: IDLE, FLY, COOL.
REQ-017 The block registers bul_sht internally; a shot request is bul_sht=1 in this cycle and 0 in the previous cycle.
REQ-018 IDLE: on a shot request with bul_en=1, the block latches tank_dir and computes the spawn cell as the tank cell moved one step in that direction.
REQ-019 Legal spawn: in the next cycle state=FLY, bul_x/bul_y = spawn cell, bul_active=1, bul_fired=1 for that one cycle.
REQ-020 Illegal spawn (x>FIELD_X_MAX, y>FIELD_Y_MAX, or a decrement from 0): the shot is discarded, the block stays in IDLE, and bul_fired stays 0.
REQ-021 FLY: on each step_tick the bullet advances one cell in bul_dir.
REQ-022 FLY: if the next cell is out of field, state goes to COOL, the outputs park at 31/31, and bul_active=0 in the next cycle.
REQ-023 FLY: hit_in=1 moves the block to COOL in the next cycle; if hit_in and step_tick coincide, hit_in wins and no move occurs.
REQ-024 Shot requests during FLY or COOL are dropped, not queued.
REQ-025 COOL: a counter loads COOLDOWN_TICKS on entry and decrements on each step_tick; at 0 the state returns to IDLE; COOLDOWN_TICKS=0 returns to IDLE in the next cycle.
REQ-026 bul_en=0 in any state forces IDLE, parked outputs, and counter cleared in the next cycle.
REQ-027 A step_tick in the same cycle as a shot request in IDLE has no effect; the first move occurs on the next step_tick after launch.
REQ-028 Arithmetic is 5-bit unsigned; the bounds check is done on the 6-bit result or borrow, so no wrap-around is ever visible on bul_x/bul_y.

Reset
REQ-029 rst=1: state=IDLE, bul_x=bul_y=5'd31, bul_active=0, bul_dir=2'b00, bul_fired=0, cooldown counter=0, registered bul_sht=0.
REQ-030 Reset mid-flight takes effect at the next clk edge; no partial move is emitted.
REQ-031 Reset has priority over all other inputs.

Structure
REQ-032 The direction encodings, the park value 31, and the state encoding SHALL live in a shared game package that the tank modules also use.
REQ-033 One sub-module, grid_step, SHALL compute the next cell and an out-of-field flag from position, direction and bounds; it is shared by spawn and flight.

Verification
REQ-034 Tank (5,5) dir 00, bul_sht rises -> next cycle bul_fired=1, bullet at (5,6); after 3 ticks bullet at (5,9).
REQ-035 Tank (0,7) dir 11, shot -> discarded; bul_active=0, bul_fired never asserts.
REQ-036 Bullet at (15,3) dir 10, tick -> parked at (31,31) and COOL; shot after 1 tick is ignored; after 2 ticks a shot is accepted.
REQ-037 Bullet in FLY at (4,4) dir 01, hit_in and step_tick in the same cycle -> bullet parked, no move to (4,3).
REQ-038 bul_sht held high for 10 cycles -> exactly one launch; rst asserted mid-flight -> all outputs at reset values on the next edge.
REQ-039 bul_en dropped during COOL with counter=1 -> IDLE next cycle; a new shot is accepted immediately after bul_en returns.
